// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with synchronous load, enable, run-time
// wrap/saturate mode, terminal-count flags and registered overflow/underflow pulses.
module updown_counter_param #(
   parameter int WIDTH   = 4,
   parameter int MIN_VAL = 0,
   parameter int MAX_VAL = (1 << WIDTH) - 1,
   parameter int STEP    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             control,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             ovf,
   output logic             unf
);

   // Range limits at count width (results) and at WIDTH+1 bits (comparisons).
   localparam logic [WIDTH-1:0] MIN_N  = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] ONE_N  = WIDTH'(1);
   localparam logic [WIDTH:0]   MIN_W  = (WIDTH+1)'(MIN_VAL);
   localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);

   logic [WIDTH-1:0] count_q;
   logic             ovf_q;
   logic             unf_q;

   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   dn_floor;
   logic             up_over;
   logic             dn_under;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] up_wrap;
   logic [WIDTH-1:0] dn_wrap;

   logic [WIDTH-1:0] count_nxt;
   logic             ovf_nxt;
   logic             unf_nxt;

   // Range checks need the carry bit; the resulting values always land
   // inside [MIN_VAL, MAX_VAL], so they are formed at count width.
   assign up_sum   = {1'b0, count_q} + STEP_W;
   assign dn_floor = MIN_W + STEP_W;
   assign up_over  = (up_sum > MAX_W);
   assign dn_under = ({1'b0, count_q} < dn_floor);

   assign up_wrap = MIN_N + (count_q + STEP_N - MAX_N - ONE_N);
   assign dn_wrap = MAX_N - (MIN_N + STEP_N - count_q - ONE_N);

   always_comb begin
      load_clamped = load_val;
      if (load_val > MAX_N) begin
         load_clamped = MAX_N;
      end else if (load_val < MIN_N) begin
         load_clamped = MIN_N;
      end
   end

   always_comb begin
      count_nxt = count_q;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
      if (load) begin
         count_nxt = load_clamped;
      end else if (en) begin
         if (control) begin
            if (!up_over) begin
               count_nxt = count_q + STEP_N;
            end else begin
               ovf_nxt   = 1'b1;
               count_nxt = mode ? MAX_N : up_wrap;
            end
         end else begin
            if (!dn_under) begin
               count_nxt = count_q - STEP_N;
            end else begin
               unf_nxt   = 1'b1;
               count_nxt = mode ? MIN_N : dn_wrap;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= MIN_N;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_nxt;
         ovf_q   <= ovf_nxt;
         unf_q   <= unf_nxt;
      end
   end

   assign count  = count_q;
   assign ovf    = ovf_q;
   assign unf    = unf_q;
   assign at_max = (count_q == MAX_N);
   assign at_min = (count_q == MIN_N);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: directed steps plus random traffic on a
// 2..11 step-3 instance and a default 0..15 step-1 instance, against an integer model.
module tb_updown_counter_param;

   localparam int MIN_A  = 2;
   localparam int MAX_A  = 11;
   localparam int STEP_A = 3;
   localparam int MIN_D  = 0;
   localparam int MAX_D  = 15;
   localparam int STEP_D = 1;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, en_a, ctl_a, mode_a, load_a;
   logic [3:0] lv_a, count_a;
   logic       at_max_a, at_min_a, ovf_a, unf_a;

   logic       rst_d, en_d, ctl_d, mode_d, load_d;
   logic [3:0] lv_d, count_d;
   logic       at_max_d, at_min_d, ovf_d, unf_d;

   updown_counter_param #(.WIDTH(4), .MIN_VAL(MIN_A), .MAX_VAL(MAX_A), .STEP(STEP_A)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .control(ctl_a), .mode(mode_a), .load(load_a),
      .load_val(lv_a), .count(count_a), .at_max(at_max_a), .at_min(at_min_a),
      .ovf(ovf_a), .unf(unf_a)
   );

   updown_counter_param dut_d (
      .clk(clk), .rst(rst_d), .en(en_d), .control(ctl_d), .mode(mode_d), .load(load_d),
      .load_val(lv_d), .count(count_d), .at_max(at_max_d), .at_min(at_min_d),
      .ovf(ovf_d), .unf(unf_d)
   );

   int         n_checks = 0;
   int         n_pass   = 0;
   int         mc_a     = MIN_A;
   int         mc_d     = MIN_D;
   logic [5:0] exp_q[$];

   // Reference: plain integer arithmetic, wrap expressed as modulo over the range.
   task automatic model_next(input int mn, input int mx, input int st,
                             input bit r, input bit ld, input int lv,
                             input bit e, input bit c, input bit m,
                             inout int cnt, output bit o, output bit u);
      int span;
      int t;
      span = mx - mn + 1;
      o = 1'b0;
      u = 1'b0;
      if (r) begin
         cnt = mn;
      end else if (ld) begin
         cnt = (lv > mx) ? mx : ((lv < mn) ? mn : lv);
      end else if (e && c) begin
         t = cnt + st;
         if (t > mx) begin
            o = 1'b1;
            cnt = m ? mx : mn + ((t - mn) % span);
         end else begin
            cnt = t;
         end
      end else if (e) begin
         t = cnt - st;
         if (t < mn) begin
            u = 1'b1;
            cnt = m ? mn : mn + ((((t - mn) % span) + span) % span);
         end else begin
            cnt = t;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // One clock on the chosen instance: drive, model, edge, compare all outputs.
   task automatic step(input int which, input string tag, input bit r, input bit ld,
                       input int lv, input bit e, input bit c, input bit m);
      bit         o, u;
      int         cnt;
      logic [5:0] item;
      int         ec;
      if (which == 0) begin
         rst_a = r; load_a = ld; lv_a = 4'(lv); en_a = e; ctl_a = c; mode_a = m;
         cnt = mc_a;
         model_next(MIN_A, MAX_A, STEP_A, r, ld, lv, e, c, m, cnt, o, u);
         mc_a = cnt;
      end else begin
         rst_d = r; load_d = ld; lv_d = 4'(lv); en_d = e; ctl_d = c; mode_d = m;
         cnt = mc_d;
         model_next(MIN_D, MAX_D, STEP_D, r, ld, lv, e, c, m, cnt, o, u);
         mc_d = cnt;
      end
      exp_q.push_back({cnt[3:0], o, u});
      @(posedge clk);
      #1;
      item = exp_q.pop_front();
      ec = 32'(item[5:2]);
      if (which == 0) begin
         check({tag, ".count"},  32'(count_a),  ec);
         check({tag, ".ovf"},    32'(ovf_a),    32'(item[1]));
         check({tag, ".unf"},    32'(unf_a),    32'(item[0]));
         check({tag, ".at_max"}, 32'(at_max_a), 32'(ec == MAX_A));
         check({tag, ".at_min"}, 32'(at_min_a), 32'(ec == MIN_A));
      end else begin
         check({tag, ".count"},  32'(count_d),  ec);
         check({tag, ".ovf"},    32'(ovf_d),    32'(item[1]));
         check({tag, ".unf"},    32'(unf_d),    32'(item[0]));
         check({tag, ".at_max"}, 32'(at_max_d), 32'(ec == MAX_D));
         check({tag, ".at_min"}, 32'(at_min_d), 32'(ec == MIN_D));
      end
   endtask

   initial begin
      rst_a = 1'b1; en_a = 1'b0; ctl_a = 1'b0; mode_a = 1'b0; load_a = 1'b0; lv_a = '0;
      rst_d = 1'b1; en_d = 1'b0; ctl_d = 1'b0; mode_d = 1'b0; load_d = 1'b0; lv_d = '0;

      // Reset beats an active up-count; then wrap 11 -> 4 with ovf.
      step(0, "rst1", 1, 0, 0, 1, 1, 0);
      step(0, "rst2", 1, 0, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++) step(0, "up_wrap", 0, 0, 0, 1, 1, 0);

      // Load 2, count down with wrap: 9, 6, 3, 10.
      step(0, "load2", 0, 1, 2, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, "dn_wrap", 0, 0, 0, 1, 0, 0);

      // Saturate at MAX with ovf every cycle, then step down to 8.
      step(0, "load11", 0, 1, 11, 1, 1, 1);
      for (int i = 0; i < 3; i++) step(0, "up_sat", 0, 0, 0, 1, 1, 1);
      step(0, "dn_after_sat", 0, 0, 0, 1, 0, 1);

      // Load clamping, with en active and ignored.
      step(0, "load15", 0, 1, 15, 1, 1, 0);
      step(0, "load0", 0, 1, 0, 1, 0, 0);
      step(0, "dn_sat_min", 0, 0, 0, 1, 0, 1);

      // Reset mid-count together with load, then hold.
      step(0, "up_pre_rst", 0, 0, 0, 1, 1, 0);
      step(0, "up_pre_rst", 0, 0, 0, 1, 1, 0);
      step(0, "rst_load", 1, 1, 9, 1, 1, 0);
      for (int i = 0; i < 5; i++) step(0, "hold", 0, 0, 0, 0, i[0], i[1]);

      for (int i = 0; i < 300; i++) begin
         step(0, "rand_a", $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 15), $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Default-parameter instance; the other instance parks in reset.
      rst_a = 1'b1;
      step(1, "d_rst", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(1, "d_up", 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 8; i++) step(1, "d_dn", 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 2; i++) step(1, "d_up2", 0, 0, 0, 1, 1, 0);
      step(1, "d_rst2", 1, 0, 0, 1, 1, 0);
      step(1, "d_load15", 0, 1, 15, 0, 0, 0);
      step(1, "d_wrap_up", 0, 0, 0, 1, 1, 0);
      step(1, "d_wrap_dn", 0, 0, 0, 1, 0, 0);

      for (int i = 0; i < 200; i++) begin
         step(1, "rand_d", $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 15), $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
